// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arb_pkg
//  Description : Shared types and constants for the eight-port bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arb_pkg;

    localparam int NUM_PORTS = 8;
    localparam int PORT_W    = $clog2(NUM_PORTS);
    localparam int DATA_W    = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef logic [DATA_W-1:0] beat_t;

endpackage
`default_nettype wire

// File: rtl/bus_port_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Finds the first set
//                request at or after ptr, wrapping from the top port to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import bus_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    idx,
    output logic                 any
);

    logic [2*NUM_PORTS-1:0] w_dbl;
    logic [NUM_PORTS-1:0]   w_rot;
    logic [PORT_W-1:0]      w_off;

    // Rotate so ptr lands at bit 0, priority-encode the lowest bit, rotate back
    always_comb begin
        w_dbl = {req, req};
        w_rot = w_dbl[{1'b0, ptr} +: NUM_PORTS];
        w_off = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PORT_W'(i);
            end
        end
        idx = w_off + ptr;
        any = |req;
    end

endmodule
`default_nettype wire

// File: rtl/bus_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_port_arbiter
//  Description : Round-robin arbiter sharing one registered data/port bus
//                between eight valid/ready requesters, with bounded bursts
//                and one arbitration bubble between consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_port_arbiter
    import bus_arb_pkg::*;
#(
    parameter int MAX_BURST = 4     // legal range 1..16
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PORTS-1:0]  req_valid,
    input  logic [DATA_W-1:0]     req_data [NUM_PORTS],
    output logic [NUM_PORTS-1:0]  req_ready,
    output logic                  bus_valid,
    output logic [DATA_W-1:0]     bus_data,
    output logic [PORT_W-1:0]     bus_port,
    input  logic                  bus_ready,
    output logic                  busy
);

    localparam int               c_CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(MAX_BURST - 1);

    arb_state_t           r_state;
    logic [PORT_W-1:0]    r_ptr;
    logic [PORT_W-1:0]    r_grant;
    logic [c_CNT_W-1:0]   r_beat_cnt;
    logic                 r_bus_valid;
    beat_t                r_bus_data;
    logic [PORT_W-1:0]    r_bus_port;

    logic                 w_load;
    logic                 w_offer;
    logic                 w_accept;
    logic [PORT_W-1:0]    w_pick_idx;
    logic                 w_pick_any;

    rr_picker u_picker (
        .req (req_valid),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Handshake terms: the output register can take a beat when empty or retiring
    always_comb begin
        w_load    = !r_bus_valid || bus_ready;
        w_offer   = (r_state == GRANT) && w_load;
        w_accept  = w_offer && req_valid[r_grant];
        req_ready = '0;
        if (w_offer) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    // Arbitration FSM, rotation pointer, burst counter and output beat register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_beat_cnt  <= '0;
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_bus_port  <= '0;
        end else begin
            if (w_accept) begin
                r_bus_valid <= 1'b1;
                r_bus_data  <= req_data[r_grant];
                r_bus_port  <= r_grant;
            end else if (bus_ready) begin
                r_bus_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant    <= w_pick_idx;
                        r_beat_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                    end
                    // A dropped request or a completed burst both release the bus
                    if (!req_valid[r_grant] || (w_accept && (r_beat_cnt == c_LAST))) begin
                        r_state <= IDLE;
                        r_ptr   <= r_grant + PORT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus_valid = r_bus_valid;
    assign bus_data  = r_bus_data;
    assign bus_port  = r_bus_port;
    assign busy      = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_bus_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_port_arbiter
//  Description : Scoreboard bench for bus_port_arbiter (MAX_BURST=4 and =1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_port_arbiter;
    import bus_arb_pkg::*;

    typedef struct {
        logic [2:0]  port;
        logic [31:0] data;
        int          gap;   // required cycles since previous beat, -1 = any
    } exp_t;

    logic clk;
    logic rst, rst_b;
    logic [7:0]  req_valid, req_ready, req_valid_b, req_ready_b;
    logic [31:0] req_data [8];
    logic [31:0] req_data_b [8];
    logic        bus_valid, bus_ready, busy;
    logic [31:0] bus_data;
    logic [2:0]  bus_port;
    logic        bus_valid_b, bus_ready_b, busy_b;
    logic [31:0] bus_data_b;
    logic [2:0]  bus_port_b;

    int n_cmp = 0;
    int n_err = 0;

    exp_t        sb  [$];
    exp_t        sbb [$];
    logic [31:0] pq  [8][$];
    logic        b_active = 1'b0;

    bus_port_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .bus_valid(bus_valid), .bus_data(bus_data),
        .bus_port(bus_port), .bus_ready(bus_ready), .busy(busy)
    );

    bus_port_arbiter #(.MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .bus_valid(bus_valid_b), .bus_data(bus_data_b),
        .bus_port(bus_port_b), .bus_ready(bus_ready_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [2:0] p, input logic [31:0] d, input int gap);
        exp_t e;
        e.port = p;
        e.data = d;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic wait_bus(input logic [31:0] d);
        int k;
        k = 0;
        while (!(bus_valid === 1'b1 && bus_data === d) && k < 100) begin
            tick(1);
            k++;
        end
        if (k >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_bus: timed out waiting for data %0h, last seen %0h", d, bus_data);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expected beats never appeared, required 0", sb.size());
            sb.delete();
        end
        tick(4);
    endtask

    // Requester model: present queue heads, pop those accepted at the edge
    initial begin
        logic [7:0] acc;
        req_valid = '0;
        for (int p = 0; p < 8; p++) req_data[p] = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid & {8{~rst}};
            @(posedge clk);
            #1;
            for (int p = 0; p < 8; p++) begin
                if (acc[p] && pq[p].size() > 0) void'(pq[p].pop_front());
            end
            #1;
            for (int p = 0; p < 8; p++) begin
                req_valid[p] = (pq[p].size() > 0);
                req_data[p]  = (pq[p].size() > 0) ? pq[p][0] : 32'h0;
            end
        end
    end

    // Monitor for the MAX_BURST=4 instance
    initial begin
        int   cyc, last;
        exp_t e;
        cyc  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus_valid === 1'b1 && bus_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: actual port %0d data %0h, required no beat", bus_port, bus_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_port", 32'(bus_port), 32'(e.port));
                    chk("beat_data", bus_data, e.data);
                    if (e.gap >= 0) chk("beat_gap", 32'(cyc - last), 32'(e.gap));
                end
                last = cyc;
            end
        end
    end

    // Monitor for the MAX_BURST=1 instance
    initial begin
        int   cyc, last;
        exp_t e;
        cyc  = 0;
        last = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (b_active && sbb.size() > 0 && bus_valid_b === 1'b1) begin
                e = sbb.pop_front();
                chk("b_port", 32'(bus_port_b), 32'(e.port));
                chk("b_data", bus_data_b, e.data);
                if (e.gap >= 0) chk("b_gap", 32'(cyc - last), 32'(e.gap));
                last = cyc;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        exp_t eb;
        rst         = 1'b1;
        rst_b       = 1'b1;
        bus_ready   = 1'b1;
        bus_ready_b = 1'b1;
        req_valid_b = 8'hFF;
        for (int p = 0; p < 8; p++) req_data_b[p] = 32'hB0 + 32'(p);
        tick(3);

        chk("rst_bus_valid", 32'(bus_valid), 0);
        chk("rst_bus_data", bus_data, 0);
        chk("rst_bus_port", 32'(bus_port), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_b_busy", 32'(busy_b), 0);
        chk("rst_b_req_ready", 32'(req_ready_b), 0);
        rst = 1'b0;
        tick(2);

        // Single requester on port 3, six beats: burst of 4, bubble, re-grant
        for (int i = 0; i < 6; i++) begin
            expect_beat(3'd3, 32'hA0 + 32'(i), (i == 0) ? -1 : ((i == 4) ? 2 : 1));
            pq[3].push_back(32'hA0 + 32'(i));
        end
        drain();

        // Park ptr at 7 by serving port 6, then offer ports 1 and 6 together
        expect_beat(3'd6, 32'h60, -1);
        pq[6].push_back(32'h60);
        drain();
        expect_beat(3'd1, 32'h11, -1);
        expect_beat(3'd1, 32'h12, 1);
        expect_beat(3'd6, 32'h61, 3);
        pq[1].push_back(32'h11);
        pq[1].push_back(32'h12);
        pq[6].push_back(32'h61);
        drain();

        // Port 2 stops after 2 beats; port 5 (above) wins over port 0
        expect_beat(3'd2, 32'h21, -1);
        expect_beat(3'd2, 32'h22, 1);
        pq[2].push_back(32'h21);
        pq[2].push_back(32'h22);
        wait_bus(32'h21);
        for (int i = 0; i < 4; i++) begin
            expect_beat(3'd5, 32'h51 + 32'(i), (i == 0) ? 3 : 1);
            pq[5].push_back(32'h51 + 32'(i));
        end
        expect_beat(3'd0, 32'h01, 2);
        pq[0].push_back(32'h01);
        drain();

        // Backpressure for 5 cycles while beat 0x42 sits in the output register
        expect_beat(3'd4, 32'h41, -1);
        expect_beat(3'd4, 32'h42, 6);
        expect_beat(3'd4, 32'h43, 1);
        expect_beat(3'd4, 32'h44, 1);
        for (int i = 0; i < 4; i++) pq[4].push_back(32'h41 + 32'(i));
        wait_bus(32'h42);
        bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_data", bus_data, 32'h42);
            chk("stall_port", 32'(bus_port), 4);
            chk("stall_req_ready", 32'(req_ready), 0);
            tick(1);
        end
        bus_ready = 1'b1;
        drain();

        // Reset while the third beat of a port-6 burst is offered
        expect_beat(3'd6, 32'h71, -1);
        expect_beat(3'd6, 32'h72, 1);
        for (int i = 0; i < 4; i++) pq[6].push_back(32'h71 + 32'(i));
        wait_bus(32'h72);
        rst = 1'b1;
        pq[2].push_back(32'h2E);
        tick(1);
        rst = 1'b0;
        chk("post_rst_bus_valid", 32'(bus_valid), 0);
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_req_ready", 32'(req_ready), 0);
        expect_beat(3'd2, 32'h2E, -1);
        expect_beat(3'd6, 32'h73, 3);
        expect_beat(3'd6, 32'h74, 1);
        drain();

        // MAX_BURST=1 instance: all eight requesters valid, strict rotation
        for (int i = 0; i < 9; i++) begin
            eb.port = 3'(i % 8);
            eb.data = 32'hB0 + 32'(i % 8);
            eb.gap  = (i == 0) ? -1 : 2;
            sbb.push_back(eb);
        end
        b_active = 1'b1;
        rst_b    = 1'b0;
        begin
            int k;
            k = 0;
            while (sbb.size() != 0 && k < 100) begin
                tick(1);
                k++;
            end
            if (k >= 100) begin
                n_cmp++;
                n_err++;
                $display("FAIL b_rotation: %0d beats missing, required 0", sbb.size());
            end
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
